// File: rtl/store_pkg.sv
// Shared types for the data-side store path: store sizes and the queued request format.
package store_pkg;

    localparam int WORD_BYTES   = 4;
    localparam int STORE_ADDR_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } store_size_t;

    typedef struct packed {
        logic [STORE_ADDR_W-1:0] addr;
        logic [31:0]             data;
        store_size_t             size;
    } store_req_t;

    // Index of the final byte of a store (bytes - 1).
    function automatic logic [1:0] last_byte_idx(store_size_t s);
        case (s)
            SZ_BYTE: last_byte_idx = 2'd0;
            SZ_HALF: last_byte_idx = 2'd1;
            SZ_WORD: last_byte_idx = 2'(WORD_BYTES - 1);
            default: last_byte_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; a push is dropped while full even if a pop coincides.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop_ok)  rptr_d = rptr_q + PW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + (PW+1)'(1);
        else if (pop_ok && !push_ok) cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/store_write_ctrl.sv
// Store path: queues CPU stores and drains each into little-endian byte writes, one per cycle.
// state  | meaning
// IDLE   | no store being written; pops the queue head when present
// WRITE  | driving one byte of the working store per cycle
module store_write_ctrl
    import store_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  PC,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  err
);

    generate
        if (DATA_WIDTH != 8) begin : g_bad_data_width
            $error("store_write_ctrl: DATA_WIDTH must be 8 for the byte RAM");
        end
        if (ADDR_WIDTH != STORE_ADDR_W) begin : g_bad_addr_width
            $error("store_write_ctrl: ADDR_WIDTH must match store_pkg::STORE_ADDR_W");
        end
    endgenerate

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [31:0]             data_q, data_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              last_q, last_d;
    logic                    err_q, err_d;

    store_req_t push_req, head_req;
    logic       accept, legal, push, pop, fifo_full, fifo_empty;

    assign accept        = req_valid && req_ready;
    assign legal         = (req_size != SZ_ILL);
    assign push          = accept && legal;
    assign push_req.addr = req_addr;
    assign push_req.data = req_data;
    assign push_req.size = store_size_t'(req_size);

    sync_fifo #(
        .WIDTH ($bits(store_req_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (PC),
        .rst_n (rst),
        .push  (push),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head_req),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        pop     = 1'b0;
        err_d   = accept && !legal;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            ST_WRITE: begin
                // idx is left at the final byte on the way to IDLE so wr_addr/din hold.
                if (idx_q == last_q) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            state_d = ST_WRITE;
            base_d  = head_req.addr;
            data_d  = head_req.data;
            idx_d   = 2'd0;
            last_d  = last_byte_idx(head_req.size);
        end
    end

    always_ff @(posedge PC or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign wr_en     = (state_q == ST_WRITE);
    assign wr_addr   = base_q + ADDR_WIDTH'(idx_q);
    assign din       = data_q[{idx_q, 3'b000} +: 8];
    assign req_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign err       = err_q;

endmodule

// File: tb/tb_store_write_ctrl.sv
// Bench for store_write_ctrl: each store becomes a scheduled window of byte writes, checked every cycle.
module tb_store_write_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          PC = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic [1:0]    req_size = '0;
    logic          req_ready, wr_en, busy, err;
    logic [AW-1:0] wr_addr;
    logic [7:0]    din;

    always #5 PC = ~PC;

    store_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
        .PC        (PC),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .din       (din),
        .busy      (busy),
        .err       (err)
    );

    // A store accepted at edge acc owns the write port after edges start .. start+nb-1.
    typedef struct {
        int          acc;
        int          start;
        int          nb;
        logic [7:0]  addr;
        logic [31:0] data;
    } store_t;

    store_t     sched[$];
    int         e = 0;
    int         next_free = 0;
    int         ill_edge = -100;
    int         checks = 0;
    int         passed = 0;
    logic       exp_ready = 1'b1;
    logic [7:0] last_addr = '0;
    logic [7:0] last_din = '0;
    bit         acc_flag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, e);
    endtask

    task automatic check_cycle();
        int         occ = 0;
        bit         bsy = 0;
        bit         we = 0;
        int         k;
        logic [7:0] a = last_addr;
        logic [7:0] d = last_din;
        foreach (sched[i]) begin
            if (sched[i].acc <= e && e < sched[i].start) occ++;
            if (sched[i].acc <= e && e <= sched[i].start + sched[i].nb - 1) bsy = 1;
            if (e >= sched[i].start && e < sched[i].start + sched[i].nb) begin
                k  = e - sched[i].start;
                we = 1;
                a  = sched[i].addr + 8'(k);
                d  = 8'(sched[i].data >> (8 * k));
            end
        end
        exp_ready = (occ < DEPTH);
        chk("wr_en", 32'(wr_en), 32'(we));
        chk("wr_addr", 32'(wr_addr), 32'(a));
        chk("din", 32'(din), 32'(d));
        chk("busy", 32'(busy), 32'(bsy));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("err", 32'(err), 32'(ill_edge == e));
        last_addr = a;
        last_din  = d;
    endtask

    task automatic tick(output bit acc);
        store_t s;
        acc = 0;
        @(posedge PC);
        e++;
        if (rst && req_valid && exp_ready) begin
            acc = 1;
            if (req_size == 2'b11) begin
                ill_edge = e;
            end else begin
                s.acc     = e;
                s.nb      = 1 << req_size;
                s.start   = (e + 1 > next_free) ? e + 1 : next_free;
                next_free = s.start + s.nb;
                s.addr    = req_addr;
                s.data    = req_data;
                sched.push_back(s);
            end
        end
        @(negedge PC);
        check_cycle();
    endtask

    task automatic idle(input int n);
        bit a;
        req_valid = 1'b0;
        repeat (n) tick(a);
    endtask

    task automatic send(input logic [7:0] a, input logic [31:0] d, input logic [1:0] s);
        bit got;
        got       = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        for (int i = 0; i < 40; i++) begin
            tick(got);
            if (got) break;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        sched.delete();
        next_free = 0;
        ill_edge  = -100;
        last_addr = '0;
        last_din  = '0;
        exp_ready = 1'b1;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1;
        chk("init_wr_en", 32'(wr_en), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_ready", 32'(req_ready), 32'd1);
        chk("init_err", 32'(err), 32'd0);
        chk("init_wr_addr", 32'(wr_addr), 32'd0);
        chk("init_din", 32'(din), 32'd0);
        repeat (2) @(posedge PC);
        @(negedge PC);
        rst = 1'b1;

        send(8'h10, 32'hDEADBEEF, 2'b10);
        idle(7);

        send(8'hFF, 32'h12345678, 2'b00);
        idle(3);
        send(8'hFF, 32'h0000ABCD, 2'b01);
        idle(4);

        for (int i = 0; i < 6; i++)
            send(8'h40 + 8'(4 * i), 32'hA0B0C0D0 + 32'(i) * 32'h01010101, 2'b10);
        idle(30);

        send(8'h20, 32'hCAFEF00D, 2'b11);
        send(8'h30, 32'hFFFFFF55, 2'b00);
        idle(5);

        send(8'h80, 32'h11223344, 2'b10);
        idle(2);
        async_reset();
        send(8'h90, 32'h000000A5, 2'b00);
        idle(6);

        for (int i = 0; i < 80; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom);
            req_data  = $urandom;
            req_size  = 2'($urandom_range(0, 3));
            tick(acc_flag);
        end
        idle(40);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/store_write_ctrl.md
Name: store_write_ctrl

Overview:
Data-side store path that issues writes into the byte-wide data RAM. It accepts CPU store requests (sb/sh/sw) through a valid/ready handshake and queues them in a small FIFO. A drain FSM splits each store into little-endian byte writes on the RAM write port, one byte per cycle. It sits between the execute stage and the RAM write port (wr_en/wr_addr/din), which is the counterpart to the RAM's existing read port.

Parameters:
ADDR_WIDTH, 8, RAM byte-address width; address arithmetic wraps modulo 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM word width; must be 8 (byte RAM); any other value is a configuration error
DEPTH, 4, store queue entries; power of two, >=2

Ports:
PC  input  1  clock; all state updates on posedge PC
rst  input  1  asynchronous reset, active-low
req_valid  input  1  store request valid
req_ready  output  1  queue can accept; equals !full
req_addr  input  ADDR_WIDTH  byte address of store
req_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_WIDTH  RAM write address
din  output  DATA_WIDTH  RAM write data
busy  output  1  queue non-empty or drain in progress
err  output  1  one-cycle pulse: illegal size request consumed

Behaviour:
- Reset (rst low, asynchronous): FIFO emptied, FSM to IDLE, wr_en=0, wr_addr=0, din=0, err=0, busy=0, req_ready=1. A store in flight is abandoned, and bytes already written stay in RAM.
- Accept: handshake completes when req_valid && req_ready at posedge. A legal size is pushed as {addr, data, size}. Size 11 is consumed but not pushed, and err=1 for exactly the next cycle.
- req_ready = !full. There is no push when full, even if a pop occurs in the same cycle. When not full, push and pop in the same cycle are both performed and the count is unchanged.
- FSM states: IDLE, WRITE.
  - IDLE: if the FIFO is non-empty, pop the head into working registers (base, data, nbytes = 1<<size, idx=0) and go to WRITE.
  - WRITE: each cycle drives wr_en=1, wr_addr=base+idx (truncated to ADDR_WIDTH, so 0xFF+1 -> 0x00), din=data[8*idx +: 8], then idx++.
  - On the last byte (idx==nbytes-1): if the FIFO is non-empty, pop the next entry and stay in WRITE, giving no bubble between stores. Otherwise go to IDLE.
- wr_en, wr_addr and din are decoded from registered state only, with no combinational path from req_*. Outside WRITE: wr_en=0 and din/wr_addr hold their last value.
- Latency: a request accepted at edge N into an empty, idle block produces its first RAM write in cycle N+2. Throughput is 1 byte per cycle.
- Order: stores drain strictly in acceptance order, bytes in ascending address order.
- busy = (state!=IDLE) || !empty, deasserting in the first cycle with no pending work.
- Unused data bits above the store size are ignored.

Decomposition:
- Package store_pkg: enum store_size_t {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11}; packed struct store_req_t {addr, data[31:0], size}; localparam WORD_BYTES=4.
- Sub-module sync_fifo (parameterised width/DEPTH, async active-low rst, push/pop/full/empty) holds store_req_t. The FSM and byte slicing stay in store_write_ctrl.

Test Plan:
- sw addr=0x10 data=0xDEADBEEF accepted at edge N -> cycles N+2..N+5 write 0x10:EF, 0x11:BE, 0x12:AD, 0x13:DE; busy falls at N+6.
- sb addr=0xFF data=0x12345678 -> single write 0xFF:78. sh addr=0xFF data=0x0000ABCD -> 0xFF:CD then 0x00:AB (wrap).
- 6 back-to-back sw (distinct data), req_valid held high -> req_ready low exactly when count==DEPTH; all 24 byte writes occur in order, wr_en continuous with no bubbles, no request lost or duplicated.
- req_size=11 with addr=0x20 -> err high exactly one cycle, no wr_en, queue count unchanged; a following sb proceeds normally.
- rst pulled low after 2 bytes of a word store -> wr_en=0 immediately (asynchronously), busy=0, req_ready=1. After release, a new sb writes correctly and the old bytes 3-4 are never written.
